bb_expr_pipe: RTL
=================

// Module: bb_expr_pipe
// PURPOSE
//  Streaming, 2-stage pipelined evaluator for the basic-block expression set
//  t1=~a&b, t2=a&~b, t3=t1|t2, t4=a^b, t5=b&~a on WIDTH-bit operand vectors.
//  It consumes (a,b) pairs through a valid/ready handshake and produces y=t3, z=t4, w=t5.
//  It is the sequential consumer of the combinational expression block. A built-in
//  equivalence monitor checks that the redundant pairs (t1,t5) and (t3,t4) agree.
// PARAMETERS
//  WIDTH   8   bit width of a, b, y, z, w
//  CNT_W   16  width of the mismatch and transfer counters
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      upstream operand pair valid
//  in_ready     out  1      block can accept operand pair this cycle
//  in_a         in   WIDTH  operand a
//  in_b         in   WIDTH  operand b
//  chk_inject   in   1      test hook: XOR bit0 of t3 on the stage-2 load in this cycle
//  out_valid    out  1      result valid
//  out_ready    in   1      downstream accepts result
//  out_y        out  WIDTH  t3 = (~a&b)|(a&~b)
//  out_z        out  WIDTH  t4 = a^b
//  out_w        out  WIDTH  t5 = b&~a
//  mismatch_cnt out  CNT_W  count of stage-2 loads where t1!=t5 or t3!=t4 (saturating)
//  mismatch_stk out  1      sticky flag, set on first mismatch
//  xfer_cnt     out  CNT_W  count of output handshakes (saturating)
// BEHAVIOUR
//  - Reset (sync, high): s1_valid=0, s2_valid=0, out_y/z/w=0, counters=0, mismatch_stk=0.
//    Reset takes priority over every other event, including a handshake in the same cycle.
//    In-flight data is discarded.
//  - Stage 1 (S1): on accept (in_valid&&in_ready), register a, b, na=~a, nb=~b.
//    The NOT of a is computed once and shared by t1 and t5.
//  - Stage 2 (S2): on advance, compute t1=na&b, t2=a&nb, t3=t1|t2, t4=a^b, t5=b&na.
//    Register y=t3^{{WIDTH-1{0}},chk_inject}, z=t4, w=t5.
//  - Advance rules: s2_adv = s1_valid && (!s2_valid || out_ready).
//    in_ready = !s1_valid || s2_adv (combinational from out_ready; no bubble at full throughput).
//  - Latency: accept at edge N -> out_valid=1 after edge N+1 when S2 is free. With out_ready=1
//    held, throughput is 1 pair/cycle.
//  - Output hold: while out_valid && !out_ready, out_y/z/w and out_valid stay stable.
//    S1 holds its data and in_ready=0 once S1 is also full.
//  - Simultaneous events: output drain and S2 reload in the same cycle are legal. Input accept
//    and S1->S2 advance in the same cycle are legal. No data is lost or duplicated.
//  - Equivalence monitor: evaluated on each s2_adv using the injected t3.
//    The mismatch term is (t1!=t5)||(t3!=t4).
//    When the mismatch term is true: mismatch_cnt+=1 (holds at 2^CNT_W-1), and mismatch_stk=1
//    until reset.
//  - xfer_cnt += 1 on each out_valid&&out_ready and saturates at all-ones; it does not wrap.
//  - Data/controls are not X-gated; in_a/in_b are only sampled on accept.
// TESTING
//  1. Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1,
//     counters=0, stk=0, out_y=0.
//  2. Single pair, WIDTH=8: a=8'hF0, b=8'h3C, out_ready=1 -> 2 cycles later out_valid=1,
//     y=8'hCC, z=8'hCC, w=8'h0C.
//  3. Stream of 256 pairs (a=i, b=~i^8'h55) with out_ready=1 -> one result per cycle.
//     Results are in order and match the reference model. xfer_cnt=256, mismatch_cnt=0.
//  4. Backpressure: out_ready=0 for 5 cycles after 3 sends -> 2 held (S1,S2), in_ready=0.
//     Outputs are stable. When out_ready rises, the 2 results drain in order with no loss.
//  5. chk_inject=1 on one S2 load with a=b=8'h00 -> y=8'h01, z=8'h00, mismatch_cnt=1,
//     mismatch_stk=1. Stk stays 1 afterwards until reset.
//  6. Saturation with CNT_W=4: 20 transfers -> xfer_cnt=4'hF. Reset mid-stream with
//     out_valid=1 -> out_valid=0 next cycle, and no stale result appears.

Source files
------------

// File: rtl/bb_expr_pipe.sv
// Two-stage streaming evaluator for y=(~a&b)|(a&~b), z=a^b, w=b&~a with a built-in
// equivalence monitor over the redundant expression pairs (t1,t5) and (t3,t4).
module bb_expr_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             chk_inject,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic [WIDTH-1:0] out_w,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             mismatch_stk,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // A producer holding valid keeps its payload stable until the transfer; ready may
    // depend combinationally on the downstream ready, valid never depends on ready.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b, s1_na, s1_nb;
    logic             s2_adv, in_acc, out_xfer;
    logic [WIDTH-1:0] t1, t2, t3, t4, t5, t3_inj;
    logic             mismatch;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s2_adv;
    assign in_acc   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // na is produced once in stage 1 and shared by t1 and t5, so the monitor sees
    // two independent AND terms built from the same inverted operand.
    always_comb begin
        t1       = s1_na & s1_b;
        t2       = s1_a & s1_nb;
        t3       = t1 | t2;
        t4       = s1_a ^ s1_b;
        t5       = s1_b & s1_na;
        t3_inj   = t3 ^ {{(WIDTH-1){1'b0}}, chk_inject};
        mismatch = (t1 != t5) || (t3_inj != t4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_na        <= '0;
            s1_nb        <= '0;
            out_valid    <= 1'b0;
            out_y        <= '0;
            out_z        <= '0;
            out_w        <= '0;
            mismatch_cnt <= '0;
            mismatch_stk <= 1'b0;
            xfer_cnt     <= '0;
        end else begin
            if (in_acc) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_na    <= ~in_a;
                s1_nb    <= ~in_b;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out_valid <= 1'b1;
                out_y     <= t3_inj;
                out_z     <= t4;
                out_w     <= t5;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end

            if (s2_adv && mismatch) begin
                mismatch_stk <= 1'b1;
                if (mismatch_cnt != {CNT_W{1'b1}})
                    mismatch_cnt <= mismatch_cnt + 1'b1;
            end

            if (out_xfer && (xfer_cnt != {CNT_W{1'b1}}))
                xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule
